// File: rtl/row_pkg.sv
// Shared types and constants for the row counter.
// State encoding, counter width and display ceiling.
package row_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } row_state_e;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] ROW_DISP_MAX = 10'd999;

  // Increment that sticks at the display ceiling.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    if (v == ROW_DISP_MAX) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD counter with enable, sync clear and wrap pulse.
// Clear and enable together load 1 (cleared, then counted).
module wrap_counter
  import row_pkg::*;
#(
  parameter int MOD = 640,
  parameter int W   = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then count the enabled beat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = en_i ? ONE : '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/row_counter.sv
// Row/column/frame counter tapped from a valid/ready pixel stream.
// Optional sticky protocol error flag: define ROW_COUNTER_ERR_EN.
module row_counter
  import row_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof_i,
  input  logic             valid_i,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_row_o,
  output logic [CNT_W-1:0] cnt_col_o,
  output logic             row_done_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             err_o
);

  // Rows are tracked unsaturated so a frame
  // taller than the display ceiling still ends.
  localparam logic [CNT_W-1:0] LAST_ROW =
    CNT_W'(IMG_HEIGHT - 1);

  row_state_e       state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic             rdone_q, rdone_d;
  logic             fdone_q, fdone_d;
  logic             busy_q;

  logic beat;
  logic col_en;
  logic col_wrap;

  assign beat   = valid_i & ready_i;
  assign col_en = beat & (sof_i | (state_q == COUNT));

  wrap_counter #(
    .MOD (IMG_WIDTH),
    .W   (CNT_W)
  ) u_col (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (sof_i),
    .en_i   (col_en),
    .cnt_o  (cnt_col_o),
    .wrap_o (col_wrap)
  );

  // Next state, row counts and completion pulses.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rows_d  = rows_q;
    rdone_d = 1'b0;
    fdone_d = 1'b0;
    if (sof_i) begin
      state_d = COUNT;
      row_d   = '0;
      rows_d  = '0;
    end else if (state_q == COUNT && col_wrap) begin
      rdone_d = 1'b1;
      row_d   = sat_inc(row_q);
      rows_d  = rows_q + 1'b1;
      if (rows_q == LAST_ROW) begin
        fdone_d = 1'b1;
        state_d = DONE;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      rows_q  <= '0;
      rdone_q <= 1'b0;
      fdone_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      rdone_q <= rdone_d;
      fdone_q <= fdone_d;
      busy_q  <= (state_d == COUNT);
    end
  end

  assign cnt_row_o    = row_q;
  assign row_done_o   = rdone_q;
  assign frame_done_o = fdone_q;
  assign busy_o       = busy_q;

`ifdef ROW_COUNTER_ERR_EN
  logic err_q;
  logic err_set;

  // Stray beats outside a frame, or a frame
  // restarted while a row is only partly filled.
  assign err_set =
    (beat & ~sof_i & (state_q != COUNT)) |
    (sof_i & (state_q == COUNT) &
     (cnt_col_o != '0));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/row_counter.md
ROW_COUNTER -- requirements
Module: row_counter

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 The parameter IMG_WIDTH SHALL default to 640 and set the number of accepted pixels per row (legal range 2..1023).
REQ-003 The parameter IMG_HEIGHT SHALL default to 480 and set the number of rows per frame (legal range 1..1023).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sof_i  input  1  start-of-frame pulse, one cycle.
REQ-007 valid_i  input  1  pixel-stream valid, tapped from the stream.
REQ-008 ready_i  input  1  pixel-stream ready, tapped from the stream; a beat is valid_i&&ready_i.
REQ-009 cnt_row_o  output  10  completed-row count for the 7-segment display stage; value is binary, 0..999.
REQ-010 cnt_col_o  output  10  accepted pixels in the current row.
REQ-011 row_done_o  output  1  one-cycle pulse when a row completes.
REQ-012 frame_done_o  output  1  one-cycle pulse when a frame completes.
REQ-013 busy_o  output  1  high while in COUNT.
REQ-014 err_o  output  1  sticky protocol-error flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-016 The FSM SHALL transition IDLE->COUNT on sof_i, COUNT->DONE on the beat that completes row IMG_HEIGHT, and DONE->COUNT on sof_i.
REQ-017 On sof_i in any state, cnt_row_o and cnt_col_o SHALL clear; a beat in the same cycle counts as the first pixel (cnt_col_o=1 the next cycle).
REQ-018 In COUNT, each beat SHALL increment cnt_col_o; on the beat where cnt_col_o==IMG_WIDTH-1, cnt_col_o SHALL wrap to 0, cnt_row_o SHALL increment, and row_done_o SHALL pulse in the next cycle.
REQ-019 The cnt_row_o increment SHALL saturate at 999; counting and the pulses continue unaffected.
REQ-020 frame_done_o SHALL pulse in the same cycle as the final row_done_o.
REQ-021 In DONE, cnt_row_o SHALL hold its final value until the next sof_i, and beats SHALL be ignored.
REQ-022 Beats in IDLE SHALL be ignored.
REQ-023 All outputs SHALL be registered, with a latency of one cycle from beat to count update.
REQ-024 Cycles with valid_i high and ready_i low SHALL NOT count.

Reset
REQ-025 Reset SHALL force state=IDLE and all outputs to 0, immediately and independent of clk.
REQ-026 Reset asserted mid-frame SHALL discard partial counts; no pulses SHALL be emitted on or after deassertion until a new sof_i.

Configuration
REQ-027 With ROW_COUNTER_ERR_EN defined, err_o SHALL set sticky (cleared only by rst) on any of: a beat in IDLE or DONE, or sof_i in COUNT with cnt_col_o!=0 (truncated row).
REQ-028 Without ROW_COUNTER_ERR_EN, err_o SHALL be tied to 0 and no error logic SHALL be synthesized.

Structure
REQ-029 The shared package row_pkg SHALL hold the state enum row_state_e, CNT_W=10 and ROW_DISP_MAX=999.
REQ-030 The column counter SHALL be a sub-module named wrap_counter (parameterized modulus, enable, sync clear, wrap pulse).

Verification (bench with IMG_WIDTH=4, IMG_HEIGHT=3)
REQ-031 Reset then sof_i then 12 continuous beats -> row_done_o pulses after beats 4, 8 and 12; frame_done_o pulses with the third; cnt_row_o=3; state DONE; busy_o=0.
REQ-032 Beats with ready_i toggling 1/0 -> only cycles with ready_i=1 count; after 8 accepted beats, cnt_row_o=2 and cnt_col_o=0.
REQ-033 sof_i coincident with a beat, mid-frame at cnt_row_o=1 and cnt_col_o=2 -> next cycle cnt_row_o=0, cnt_col_o=1; err_o=1 with the macro and 0 without.
REQ-034 IMG_WIDTH=2, IMG_HEIGHT=1023, with 2046 beats -> cnt_row_o stops at 999; frame_done_o pulses once.
REQ-035 rst asserted mid-row between clock edges -> outputs are 0 before the next edge; 5 further beats with no sof_i -> counts stay 0.
REQ-036 5 beats in IDLE before any sof_i -> counts stay 0; err_o=1 only with ROW_COUNTER_ERR_EN defined.
